// File: rtl/sw_input_frontend.sv
// rtl/sw_input_frontend.sv - synchronizes and debounces board switches and buttons into the ALU operand and function selector
module sw_input_frontend #(
  parameter int BITS            = 16,
  parameter int FUNC_W          = 3,
  parameter int NUM_FUNCS       = 8,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BITS-1:0]   sw_raw,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              btn_load,
  output logic [BITS-1:0]   sw_out,
  output logic [FUNC_W-1:0] alu_func,
  output logic [BITS-1:0]   sw_stable,
  output logic              update
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FUNC_W-1:0] FUNC_LAST = FUNC_W'(NUM_FUNCS - 1);

  typedef enum logic [1:0] {IDLE, CNT_PRESS, PRESSED, CNT_REL} btn_state_t;

  // button index: 0 = next, 1 = prev, 2 = load
  logic [2:0]       btn_s1, btn_s2;
  logic [2:0]       pulse_q, pulse_d;
  btn_state_t       state_q [3];
  btn_state_t       state_d [3];
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [BITS-1:0]  sw_s1, sw_s2, sw_prev;
  logic [CNT_W-1:0] sw_cnt;
  logic             step_next, step_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= {btn_load, btn_prev, btn_next};
      btn_s2 <= btn_s1;
      sw_s1  <= sw_raw;
      sw_s2  <= sw_s1;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pulse_d[i] = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (btn_s2[i]) begin
            state_d[i] = CNT_PRESS;
            cnt_d[i]   = '0;
          end
        end
        CNT_PRESS: begin
          if (!btn_s2[i]) begin
            state_d[i] = IDLE;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = PRESSED;
            pulse_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!btn_s2[i]) begin
            state_d[i] = CNT_REL;
            cnt_d[i]   = '0;
          end
        end
        CNT_REL: begin
          if (btn_s2[i]) begin
            state_d[i] = PRESSED;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pulse_q <= pulse_d;
    end
  end

  // The counter saturates once the vector has settled, so a later change is
  // accepted only after a fresh full stable window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_prev   <= '0;
      sw_cnt    <= '0;
      sw_stable <= '0;
    end else begin
      sw_prev <= sw_s2;
      if (sw_s2 != sw_prev) begin
        sw_cnt <= '0;
      end else if (sw_cnt != CNT_LAST) begin
        sw_cnt <= sw_cnt + CNT_W'(1);
      end else if (sw_s2 != sw_stable) begin
        sw_stable <= sw_s2;
      end
    end
  end

  assign step_next = pulse_q[0] & ~pulse_q[1];
  assign step_prev = pulse_q[1] & ~pulse_q[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_out   <= '0;
      alu_func <= '0;
      update   <= 1'b0;
    end else begin
      update <= step_next | step_prev | pulse_q[2];
      if (pulse_q[2]) begin
        sw_out <= sw_stable;
      end
      if (step_next) begin
        alu_func <= (alu_func == FUNC_LAST) ? '0 : alu_func + FUNC_W'(1);
      end else if (step_prev) begin
        alu_func <= (alu_func == '0) ? FUNC_LAST : alu_func - FUNC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sw_input_frontend.sv
// tb/tb_sw_input_frontend.sv - directed and randomized checks of sw_input_frontend against a run-length reference model
module tb_sw_input_frontend;
  localparam int D  = 4;
  localparam int NF = 8;

  logic        clk;
  logic        rst_n;
  logic [15:0] sw_raw;
  logic        btn_next, btn_prev, btn_load;
  logic [15:0] sw_out;
  logic [2:0]  alu_func;
  logic [15:0] sw_stable;
  logic        update;

  sw_input_frontend #(
    .BITS(16), .FUNC_W(3), .NUM_FUNCS(NF), .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw),
    .btn_next(btn_next), .btn_prev(btn_prev), .btn_load(btn_load),
    .sw_out(sw_out), .alu_func(alu_func), .sw_stable(sw_stable), .update(update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference: a button level flips after D+1 consecutive synchronized samples
  // of the opposite value; the switch vector is accepted after D+1 identical samples.
  int          m_alu;
  logic [15:0] m_sw_out, m_stable, m_sw_s1, m_sw_s2;
  bit          m_update;
  bit [2:0]    m_pulse, m_s1, m_s2;
  bit          lvl [3];
  int          run [3];
  logic [15:0] hist [$];

  function automatic void model_edge();
    bit [2:0] np;
    bit       wr;
    bit       all_eq;
    bit       in;
    np = '0;
    wr = 1'b0;
    if (!rst_n) begin
      m_alu = 0; m_sw_out = '0; m_stable = '0; m_update = 1'b0;
      m_pulse = '0; m_s1 = '0; m_s2 = '0; m_sw_s1 = '0; m_sw_s2 = '0;
      for (int i = 0; i < 3; i++) begin
        lvl[i] = 1'b0;
        run[i] = 0;
      end
      hist = {};
      repeat (D + 1) hist.push_back(16'h0);
      return;
    end
    if (m_pulse[0] != m_pulse[1]) begin
      m_alu = m_pulse[0] ? (m_alu + 1) % NF : (m_alu + NF - 1) % NF;
      wr = 1'b1;
    end
    if (m_pulse[2]) begin
      m_sw_out = m_stable;
      wr = 1'b1;
    end
    m_update = wr;
    hist.push_back(m_sw_s2);
    if (hist.size() > D + 1) void'(hist.pop_front());
    all_eq = 1'b1;
    foreach (hist[k]) if (hist[k] !== hist[D]) all_eq = 1'b0;
    if (all_eq && hist[D] !== m_stable) m_stable = hist[D];
    for (int i = 0; i < 3; i++) begin
      in = m_s2[i];
      if (in != lvl[i]) begin
        run[i]++;
        if (run[i] == D + 1) begin
          lvl[i] = in;
          run[i] = 0;
          np[i]  = in;
        end
      end else begin
        run[i] = 0;
      end
    end
    m_pulse = np;
    m_s2    = m_s1;
    m_s1    = {btn_load, btn_prev, btn_next};
    m_sw_s2 = m_sw_s1;
    m_sw_s1 = sw_raw;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("alu_func",  32'(alu_func),  32'(m_alu));
    check("sw_out",    32'(sw_out),    32'(m_sw_out));
    check("sw_stable", 32'(sw_stable), 32'(m_stable));
    check("update",    32'(update),    32'(m_update));
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       btn_next = v;
      1:       btn_prev = v;
      default: btn_load = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    ticks(8);
    set_btn(b, 1'b0);
    ticks(8);
  endtask

  initial begin
    int hl [3];
    int sl;
    rst_n = 1'b0; sw_raw = '0;
    btn_next = 1'b0; btn_prev = 1'b0; btn_load = 1'b0;
    ticks(2);
    check("rst_alu", 32'(alu_func), 32'd0);
    check("rst_update", 32'(update), 32'd0);
    rst_n = 1'b1;
    ticks(3);

    // next held 20 cycles: single step 0 -> 1
    btn_next = 1'b1;
    ticks(20);
    check("held_next", 32'(alu_func), 32'd1);
    btn_next = 1'b0;
    ticks(10);

    // wrap forward and backward
    repeat (6) press(0);
    check("to_seven", 32'(alu_func), 32'd7);
    press(0);
    check("wrap_next", 32'(alu_func), 32'd0);
    press(1);
    check("wrap_prev", 32'(alu_func), 32'd7);

    // short glitch, then release bounce
    btn_next = 1'b1; ticks(3);
    btn_next = 1'b0; ticks(10);
    check("glitch", 32'(alu_func), 32'd7);
    btn_next = 1'b1; ticks(8);
    btn_next = 1'b0; ticks(2);
    btn_next = 1'b1; ticks(2);
    btn_next = 1'b0; ticks(10);
    check("bounce", 32'(alu_func), 32'd0);

    // simultaneous next and prev
    btn_next = 1'b1; btn_prev = 1'b1; ticks(12);
    btn_next = 1'b0; btn_prev = 1'b0; ticks(10);
    check("both", 32'(alu_func), 32'd0);

    // switch debounce and load
    sw_raw = 16'hA5C3;
    ticks(10);
    check("stable_a5c3", 32'(sw_stable), 32'hA5C3);
    press(2);
    check("load_a5c3", 32'(sw_out), 32'hA5C3);
    for (int t = 0; t < 10; t++) begin
      sw_raw = t[0] ? 16'hA5C3 : 16'h1234;
      ticks(2);
    end
    check("toggle_hold", 32'(sw_stable), 32'hA5C3);
    ticks(10);

    // reset mid-debounce with button held
    btn_next = 1'b1;
    ticks(5);
    rst_n = 1'b0;
    tick();
    check("midrst_alu", 32'(alu_func), 32'd0);
    check("midrst_sw_out", 32'(sw_out), 32'd0);
    rst_n = 1'b1;
    ticks(15);
    check("post_rst_step", 32'(alu_func), 32'd1);
    btn_next = 1'b0;
    ticks(10);

    // randomized buttons, switches and occasional reset
    hl = '{0, 0, 0};
    sl = 0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (hl[b] == 0) begin
          set_btn(b, 1'($urandom_range(0, 1)));
          hl[b] = $urandom_range(1, 10);
        end else begin
          hl[b]--;
        end
      end
      if (sl == 0) begin
        sw_raw = 16'($urandom);
        sl = $urandom_range(1, 12);
      end else begin
        sl--;
      end
      rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sw_input_frontend.md
SW_INPUT_FRONTEND -- requirements
Module: sw_input_frontend

Interface
REQ-001 SHALL have parameter BITS, default 16, width of the switch operand bus.
REQ-002 SHALL have parameter FUNC_W, default 3, width of the ALU function selector.
REQ-003 SHALL have parameter NUM_FUNCS, default 8, number of valid selector codes (0..NUM_FUNCS-1), NUM_FUNCS <= 2**FUNC_W.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, number of stable cycles required to accept a level (10 ms at 100 MHz).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have port sw_raw, input, BITS, asynchronous board slide switches.
REQ-008 SHALL have port btn_next, input, 1, asynchronous push-button, advance selector.
REQ-009 SHALL have port btn_prev, input, 1, asynchronous push-button, step selector back.
REQ-010 SHALL have port btn_load, input, 1, asynchronous push-button, latch switches into sw_out.
REQ-011 SHALL have port sw_out, output, BITS, latched operand driving the ALU SW input.
REQ-012 SHALL have port alu_func, output, FUNC_W, registered selector driving the ALU function input.
REQ-013 SHALL have port sw_stable, output, BITS, debounced live switch value.
REQ-014 SHALL have port update, output, 1, one-cycle pulse whenever sw_out or alu_func changed on the previous edge.

Function
REQ-015 SHALL pass every raw input through a two-flop synchronizer (s1, s2) before any other use.
REQ-016 SHALL debounce each button with its own 4-state FSM: IDLE, CNT_PRESS, PRESSED, CNT_REL, plus a counter sized for DEBOUNCE_CYCLES.
REQ-017 IDLE: s2=1 -> CNT_PRESS, counter=0; otherwise stay.
REQ-018 CNT_PRESS: s2=0 -> IDLE; counter==DEBOUNCE_CYCLES-1 -> PRESSED and assert that button's press pulse for exactly one cycle; else counter+1.
REQ-019 PRESSED: s2=0 -> CNT_REL, counter=0; otherwise stay, no further pulses while held.
REQ-020 CNT_REL: s2=1 -> PRESSED (no pulse); counter==DEBOUNCE_CYCLES-1 -> IDLE; else counter+1.
REQ-021 Press latency: with edge 0 = first edge sampling the button high and the button held, press pulse SHALL be high in the cycle after edge DEBOUNCE_CYCLES+2; the resulting output change SHALL appear after edge DEBOUNCE_CYCLES+3.
REQ-022 SHALL debounce the switch bus as one vector: counter clears whenever synchronized vector differs from its previous-cycle value; when it has been equal to itself for DEBOUNCE_CYCLES consecutive cycles and differs from sw_stable, sw_stable SHALL load it.
REQ-023 next pulse alone: alu_func = (alu_func==NUM_FUNCS-1) ? 0 : alu_func+1.
REQ-024 prev pulse alone: alu_func = (alu_func==0) ? NUM_FUNCS-1 : alu_func-1.
REQ-025 next and prev pulses in the same cycle: alu_func unchanged, no update pulse from selector.
REQ-026 load pulse: sw_out <= sw_stable; a load in the same cycle as a selector change SHALL perform both.
REQ-027 update SHALL assert one cycle after any edge on which sw_out or alu_func was written, including a load that writes an identical value.
REQ-028 sw_out SHALL never follow sw_raw or sw_stable except on a load pulse.

Reset
REQ-029 On a rising clk edge with rst_n=0: sw_out=0, alu_func=0, sw_stable=0, update=0, all button FSMs IDLE, all counters 0, synchronizer flops 0.
REQ-030 Reset asserted mid-debounce or while a button is held SHALL abort counting; after release a still-held button SHALL produce exactly one pulse after full debounce latency.

Verification (DEBOUNCE_CYCLES=4, NUM_FUNCS=8)
REQ-031 btn_next held 20 cycles from reset -> alu_func 0->1 after edge 7, one update pulse, no second step while held.
REQ-032 alu_func=7, one clean btn_next press -> alu_func=0; alu_func=0, one btn_prev press -> 7.
REQ-033 btn_next glitch high 3 cycles then low -> no pulse, alu_func unchanged; release bounce 2 cycles during CNT_REL -> no extra pulse.
REQ-034 btn_next and btn_prev asserted on the same edge, held -> alu_func unchanged, update never asserts.
REQ-035 sw_raw=16'hA5C3 stable 10 cycles, then btn_load press -> sw_stable=16'hA5C3 first, sw_out=16'hA5C3 after load latency, update one cycle; sw_raw toggling every 2 cycles -> sw_stable holds.
REQ-036 rst_n low for 1 cycle at counter=2 of btn_next press, button still held -> all outputs 0, then exactly one increment to 1 after full latency.
